// File: rtl/sdram_avl_master.sv
// ---------------------------------------------------------------------------
// sdram_avl_master
//
// Request-side front end for an SDRAM controller's Avalon-MM slave port.
// Client read/write requests arrive on a valid/ready stream and are buffered
// in a small command FIFO. An issue FSM pops them in order onto the Avalon
// bus and holds each command while waitrequest is high. It also limits how
// many reads may be outstanding at once. Read data returns to the client on
// a registered, un-backpressured response stream.
//
// Ports
//   clk_clk, reset_reset        clock, asynchronous active-high reset
//   req_valid/req_ready         client request handshake
//   req_write/addr/wdata/be     request payload (be active-high)
//   rsp_valid/rsp_data          one-cycle read-data pulse, in request order
//   busy                        FIFO non-empty, command on bus, or reads pending
//   err_unexp                   sticky: readdatavalid with no read outstanding
//   sdram_*                     Avalon-MM master side (active-low strobes/be)
// ---------------------------------------------------------------------------
module sdram_avl_master #(
    parameter int ADDR_W     = 25,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_RD     = 4
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [1:0]        req_be,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              err_unexp,
    output logic [ADDR_W-1:0] sdram_address,
    output logic [1:0]        sdram_byteenable_n,
    output logic              sdram_chipselect,
    output logic              sdram_read_n,
    output logic              sdram_write_n,
    output logic [DATA_W-1:0] sdram_writedata,
    input  logic [DATA_W-1:0] sdram_readdata,
    input  logic              sdram_readdatavalid,
    input  logic              sdram_waitrequest
);

    localparam int              PTR_W   = $clog2(FIFO_DEPTH);
    localparam int              ENTRY_W = 1 + ADDR_W + DATA_W + 2;
    localparam logic [PTR_W:0]  PTR_ONE = 1;
    localparam logic [3:0]      MAX_RD_C = 4'(MAX_RD);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CMD  = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Command FIFO. Pointers carry one extra wrap bit so full and empty
    // are distinguishable without a separate occupancy counter.
    // ------------------------------------------------------------------
    logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]     wr_ptr_reg;
    logic [PTR_W:0]     rd_ptr_reg;
    logic               ready_en_reg;
    logic               fifo_empty;
    logic               fifo_full;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] head;
    logic               head_write;
    logic [ADDR_W-1:0]  head_addr;
    logic [DATA_W-1:0]  head_wdata;
    logic [1:0]         head_be;

    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                        (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);

    // ready_en_reg keeps req_ready low while reset is held and for the
    // remainder of that cycle after release.
    assign req_ready = ready_en_reg && !fifo_full;
    assign push      = req_valid && req_ready;

    always_ff @(posedge clk_clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg[PTR_W-1:0]] <= {req_write, req_addr, req_wdata, req_be};
        end
    end

    assign head       = fifo_mem[rd_ptr_reg[PTR_W-1:0]];
    assign head_write = head[ENTRY_W-1];
    assign head_addr  = head[ENTRY_W-2 -: ADDR_W];
    assign head_wdata = head[DATA_W+1:2];
    assign head_be    = head[1:0];

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            ready_en_reg <= 1'b0;
        end else begin
            ready_en_reg <= 1'b1;
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Issue FSM and registered Avalon outputs
    // ------------------------------------------------------------------
    state_t             state_reg, state_next;
    logic               cs_reg, cs_next;
    logic               rd_n_reg, rd_n_next;
    logic               wr_n_reg, wr_n_next;
    logic [ADDR_W-1:0]  addr_reg, addr_next;
    logic [DATA_W-1:0]  wdata_reg, wdata_next;
    logic [1:0]         be_n_reg, be_n_next;
    logic               load;
    logic               head_ok;
    logic               rd_accept;

    logic [3:0]         cnt_reg, cnt_next;
    logic               err_reg;
    logic               err_set;
    logic               rsp_valid_reg;
    logic [DATA_W-1:0]  rsp_data_reg;

    assign rd_accept = (state_reg == ST_CMD) && !sdram_waitrequest && !rd_n_reg;

    // Eligibility uses the count as it will stand after this edge, so a
    // read accepted on this very edge is already counted against the limit
    // and a slot freed by readdatavalid on this edge can be reused at once.
    assign head_ok = !fifo_empty && (head_write || (cnt_next < MAX_RD_C));

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        pop        = 1'b0;
        cs_next    = cs_reg;
        rd_n_next  = rd_n_reg;
        wr_n_next  = wr_n_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        be_n_next  = be_n_reg;
        case (state_reg)
            ST_IDLE: begin
                load = head_ok;
            end
            ST_CMD: begin
                if (!sdram_waitrequest) begin
                    if (head_ok) begin
                        load = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                        cs_next    = 1'b0;
                        rd_n_next  = 1'b1;
                        wr_n_next  = 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (load) begin
            pop        = 1'b1;
            state_next = ST_CMD;
            cs_next    = 1'b1;
            rd_n_next  = head_write;
            wr_n_next  = !head_write;
            addr_next  = head_addr;
            wdata_next = head_wdata;
            be_n_next  = ~head_be;
        end
    end

    // Outstanding-read counter. Data arriving with nothing outstanding is
    // flagged rather than allowed to wrap the counter.
    always_comb begin
        cnt_next = cnt_reg;
        err_set  = sdram_readdatavalid && (cnt_reg == 4'd0);
        if (rd_accept && !(sdram_readdatavalid && cnt_reg != 4'd0)) begin
            cnt_next = cnt_reg + 4'd1;
        end else if (!rd_accept && sdram_readdatavalid && cnt_reg != 4'd0) begin
            cnt_next = cnt_reg - 4'd1;
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_reg     <= ST_IDLE;
            cs_reg        <= 1'b0;
            rd_n_reg      <= 1'b1;
            wr_n_reg      <= 1'b1;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            be_n_reg      <= 2'b11;
            cnt_reg       <= 4'd0;
            err_reg       <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            cs_reg        <= cs_next;
            rd_n_reg      <= rd_n_next;
            wr_n_reg      <= wr_n_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            be_n_reg      <= be_n_next;
            cnt_reg       <= cnt_next;
            if (err_set) err_reg <= 1'b1;
            rsp_valid_reg <= sdram_readdatavalid;
            if (sdram_readdatavalid) rsp_data_reg <= sdram_readdata;
        end
    end

    assign sdram_chipselect   = cs_reg;
    assign sdram_read_n       = rd_n_reg;
    assign sdram_write_n      = wr_n_reg;
    assign sdram_address      = addr_reg;
    assign sdram_writedata    = wdata_reg;
    assign sdram_byteenable_n = be_n_reg;
    assign rsp_valid          = rsp_valid_reg;
    assign rsp_data           = rsp_data_reg;
    assign err_unexp          = err_reg;
    assign busy               = !fifo_empty || cs_reg || (cnt_reg != 4'd0);

endmodule
